regfile_wb_ctrl: RTL and testbench

//  Write-back controller: the write side of the dual-issue register file. Registers the two

---
 rtl/regfile_wb_ctrl_pkg.sv | 17 +
 rtl/regfile_wb_ctrl_if.sv | 42 ++++
 rtl/regfile_wb_ctrl_ll_fifo.sv | 72 +++++++
 rtl/regfile_wb_ctrl.sv | 110 +++++++++++
 tb/tb_regfile_wb_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// rtl/regfile_wb_ctrl_pkg.sv - shared widths, register-file constants and drain decision type
package regfile_wb_ctrl_pkg;

  localparam int REG_BUS_W    = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int NOP_REG_ADDR = 0;
  localparam int ZERO_WORD    = 0;

  // What happens to the LL FIFO head in the current cycle
  typedef enum logic [1:0] {
    DRAIN_NONE,
    DRAIN_P1,
    DRAIN_P2,
    DRAIN_DROP
  } drain_e;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// rtl/regfile_wb_ctrl_if.sv - issue-slot, long-latency and regfile write-port bundle
interface regfile_wb_ctrl_if
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W
);

  logic                   s1_we;
  logic [ADDR_W-1:0]      s1_waddr;
  logic [DATA_W-1:0]      s1_wdata;
  logic                   s2_we;
  logic [ADDR_W-1:0]      s2_waddr;
  logic [DATA_W-1:0]      s2_wdata;
  logic                   ll_valid;
  logic [ADDR_W-1:0]      ll_waddr;
  logic [DATA_W-1:0]      ll_wdata;
  logic                   ll_ready;
  logic                   stall_req;
  logic [2**ADDR_W-1:0]   ll_pend;
  logic                   we1;
  logic [ADDR_W-1:0]      waddr1;
  logic [DATA_W-1:0]      wdata1;
  logic                   we2;
  logic [ADDR_W-1:0]      waddr2;
  logic [DATA_W-1:0]      wdata2;

  modport master (
    output s1_we, s1_waddr, s1_wdata, s2_we, s2_waddr, s2_wdata,
    output ll_valid, ll_waddr, ll_wdata,
    input  ll_ready, stall_req, ll_pend,
    input  we1, waddr1, wdata1, we2, waddr2, wdata2
  );

  modport slave (
    input  s1_we, s1_waddr, s1_wdata, s2_we, s2_waddr, s2_wdata,
    input  ll_valid, ll_waddr, ll_wdata,
    output ll_ready, stall_req, ll_pend,
    output we1, waddr1, wdata1, we2, waddr2, wdata2
  );

endinterface

// File: rtl/regfile_wb_ctrl_ll_fifo.sv
// rtl/regfile_wb_ctrl_ll_fifo.sv - synchronous FIFO of {waddr,wdata} for long-latency results
module wb_ll_fifo
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_addr,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [ADDR_W-1:0]             head_addr,
  output logic [DATA_W-1:0]             head_data,
  output logic                          full,
  output logic                          empty,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] mem_addr;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data;
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [CNT_W-1:0]             count;
  logic                         push_eff;
  logic                         pop_eff;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop_eff   = pop && !empty;
  // A full FIFO can still take a push in the same cycle the head leaves
  assign push_eff  = push && (!full || pop_eff);
  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign entry_addr = mem_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_eff) - CNT_W'(pop_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  always_comb begin
    logic [PTR_W-1:0] off;
    off         = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PTR_W'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, off} < count);
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - dual-port register-file write-back with LL result drain and starvation stall
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int DATA_W     = REG_BUS_W,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int LL_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  regfile_wb_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] NOP_ADDR = ADDR_W'(NOP_REG_ADDR);
  localparam logic [DATA_W-1:0] ZERO_W   = DATA_W'(ZERO_WORD);
  localparam int                SCNT_W   = $clog2(STARVE_MAX + 1);

  logic                           s1_act, s2_act;
  logic                           full, empty, push, pop;
  logic [ADDR_W-1:0]              head_addr;
  logic [DATA_W-1:0]              head_data;
  logic [LL_DEPTH-1:0]            entry_valid;
  logic [LL_DEPTH-1:0][ADDR_W-1:0] entry_addr;
  drain_e                         drain;
  logic [SCNT_W-1:0]              starve_cnt;
  logic                           stall_q;

  assign s1_act = bus.s1_we && (bus.s1_waddr != NOP_ADDR);
  assign s2_act = bus.s2_we && (bus.s2_waddr != NOP_ADDR);

  assign bus.ll_ready  = !full;
  assign bus.stall_req = stall_q;
  // r0 results are handshaken but never stored
  assign push = bus.ll_valid && !full && (bus.ll_waddr != NOP_ADDR);
  assign pop  = (drain != DRAIN_NONE);

  wb_ll_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (LL_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (bus.ll_waddr),
    .push_data   (bus.ll_wdata),
    .pop         (pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .full        (full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // A slot writing the head's register makes the older LL value dead
  always_comb begin
    drain = DRAIN_NONE;
    if (!empty) begin
      if ((s1_act && bus.s1_waddr == head_addr) || (s2_act && bus.s2_waddr == head_addr))
        drain = DRAIN_DROP;
      else if (!s1_act)
        drain = DRAIN_P1;
      else if (!s2_act)
        drain = DRAIN_P2;
    end
  end

  always_comb begin
    bus.ll_pend = '0;
    for (int i = 0; i < LL_DEPTH; i++) begin
      if (entry_valid[i] && entry_addr[i] != NOP_ADDR)
        bus.ll_pend[entry_addr[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.we1    <= 1'b0;
      bus.waddr1 <= NOP_ADDR;
      bus.wdata1 <= ZERO_W;
      bus.we2    <= 1'b0;
      bus.waddr2 <= NOP_ADDR;
      bus.wdata2 <= ZERO_W;
    end else begin
      bus.we1    <= s1_act || (drain == DRAIN_P1);
      bus.waddr1 <= (drain == DRAIN_P1) ? head_addr : (s1_act ? bus.s1_waddr : NOP_ADDR);
      bus.wdata1 <= (drain == DRAIN_P1) ? head_data : (s1_act ? bus.s1_wdata : ZERO_W);
      bus.we2    <= s2_act || (drain == DRAIN_P2);
      bus.waddr2 <= (drain == DRAIN_P2) ? head_addr : (s2_act ? bus.s2_waddr : NOP_ADDR);
      bus.wdata2 <= (drain == DRAIN_P2) ? head_data : (s2_act ? bus.s2_wdata : ZERO_W);
    end
  end

  // Counter saturates at STARVE_MAX; the stall is raised one cycle after it gets there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else if (pop || empty) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (starve_cnt != SCNT_W'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
      else                                    stall_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - directed self-checking bench for regfile_wb_ctrl
module tb_regfile_wb_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_wb_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_ctrl #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .LL_DEPTH   (4),
    .STARVE_MAX (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.s1_we = 1'b0; bus.s1_waddr = '0; bus.s1_wdata = '0;
    bus.s2_we = 1'b0; bus.s2_waddr = '0; bus.s2_wdata = '0;
    bus.ll_valid = 1'b0; bus.ll_waddr = '0; bus.ll_wdata = '0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle_inputs();
    repeat (2) tick();
    checks++;
    if ({bus.we1, bus.waddr1, bus.wdata1, bus.we2, bus.waddr2, bus.wdata2} !== 76'd0) begin
      $display("FAIL reset_ports got=%0h exp=0", {bus.we1, bus.waddr1, bus.wdata1, bus.we2, bus.waddr2, bus.wdata2});
      failures++;
    end
    checks++;
    if ({bus.ll_ready, bus.stall_req, bus.ll_pend} !== {1'b1, 1'b0, 32'h0}) begin
      $display("FAIL reset_status got ready=%0b stall=%0b pend=%h exp ready=1 stall=0 pend=0", bus.ll_ready, bus.stall_req, bus.ll_pend);
      failures++;
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_slots;
    bus.s1_we = 1'b1; bus.s1_waddr = 5'd5; bus.s1_wdata = 32'h11;
    bus.s2_we = 1'b1; bus.s2_waddr = 5'd6; bus.s2_wdata = 32'h22;
    tick();
    checks++;
    if ({bus.we1, bus.waddr1, bus.wdata1} !== {1'b1, 5'd5, 32'h11}) begin
      $display("FAIL slots_port1 got=%b/%0d/%h exp=1/5/11", bus.we1, bus.waddr1, bus.wdata1);
      failures++;
    end
    checks++;
    if ({bus.we2, bus.waddr2, bus.wdata2} !== {1'b1, 5'd6, 32'h22}) begin
      $display("FAIL slots_port2 got=%b/%0d/%h exp=1/6/22", bus.we2, bus.waddr2, bus.wdata2);
      failures++;
    end
    idle_inputs();
    tick();
    checks++;
    if ({bus.we1, bus.we2} !== 2'b00) begin
      $display("FAIL slots_idle got we1=%b we2=%b exp 0 0", bus.we1, bus.we2);
      failures++;
    end
  endtask

  task automatic test_zero_addr;
    bus.s1_we = 1'b1; bus.s1_waddr = 5'd0; bus.s1_wdata = 32'h33;
    bus.ll_valid = 1'b1; bus.ll_waddr = 5'd0; bus.ll_wdata = 32'hFF;
    #1;
    checks++;
    if (bus.ll_ready !== 1'b1) begin
      $display("FAIL zero_ll_ready got=%b exp=1", bus.ll_ready);
      failures++;
    end
    tick();
    idle_inputs();
    checks++;
    if ({bus.we1, bus.ll_pend} !== {1'b0, 32'h0}) begin
      $display("FAIL zero_s1 got we1=%b pend=%h exp we1=0 pend=0", bus.we1, bus.ll_pend);
      failures++;
    end
    tick();
    checks++;
    if ({bus.we1, bus.we2, bus.ll_ready} !== 3'b001) begin
      $display("FAIL zero_ll_never_written got we1=%b we2=%b ready=%b exp 0 0 1", bus.we1, bus.we2, bus.ll_ready);
      failures++;
    end
  endtask

  task automatic test_drain_port2;
    bus.ll_valid = 1'b1; bus.ll_waddr = 5'd9; bus.ll_wdata = 32'hAB;
    bus.s1_we = 1'b1; bus.s1_waddr = 5'd3; bus.s1_wdata = 32'h33;
    tick();
    checks++;
    if (bus.ll_pend !== 32'h0000_0200) begin
      $display("FAIL drain_pend_set got=%h exp=00000200", bus.ll_pend);
      failures++;
    end
    bus.ll_valid = 1'b0;
    bus.s1_wdata = 32'h34;
    tick();
    checks++;
    if ({bus.we2, bus.waddr2, bus.wdata2} !== {1'b1, 5'd9, 32'hAB}) begin
      $display("FAIL drain_port2 got=%b/%0d/%h exp=1/9/ab", bus.we2, bus.waddr2, bus.wdata2);
      failures++;
    end
    checks++;
    if ({bus.we1, bus.waddr1, bus.wdata1, bus.ll_pend} !== {1'b1, 5'd3, 32'h34, 32'h0}) begin
      $display("FAIL drain_port1_pend got=%b/%0d/%h pend=%h exp=1/3/34 pend=0", bus.we1, bus.waddr1, bus.wdata1, bus.ll_pend);
      failures++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_supersede;
    bus.ll_valid = 1'b1; bus.ll_waddr = 5'd7; bus.ll_wdata = 32'h77;
    tick();
    checks++;
    if (bus.ll_pend !== 32'h0000_0080) begin
      $display("FAIL supersede_pend_set got=%h exp=00000080", bus.ll_pend);
      failures++;
    end
    bus.ll_valid = 1'b0;
    bus.s2_we = 1'b1; bus.s2_waddr = 5'd7; bus.s2_wdata = 32'h70;
    tick();
    idle_inputs();
    checks++;
    if ({bus.we1, bus.we2, bus.waddr2, bus.wdata2, bus.ll_pend} !== {1'b0, 1'b1, 5'd7, 32'h70, 32'h0}) begin
      $display("FAIL supersede_drop got we1=%b p2=%b/%0d/%h pend=%h exp we1=0 p2=1/7/70 pend=0",
               bus.we1, bus.we2, bus.waddr2, bus.wdata2, bus.ll_pend);
      failures++;
    end
    tick();
    checks++;
    if ({bus.we1, bus.we2} !== 2'b00) begin
      $display("FAIL supersede_no_late_write got we1=%b we2=%b exp 0 0", bus.we1, bus.we2);
      failures++;
    end
  endtask

  task automatic test_starvation;
    bus.s1_we = 1'b1; bus.s1_waddr = 5'd1; bus.s1_wdata = 32'h1;
    bus.s2_we = 1'b1; bus.s2_waddr = 5'd2; bus.s2_wdata = 32'h2;
    for (int i = 0; i < 4; i++) begin
      bus.ll_valid = 1'b1; bus.ll_waddr = 5'(10 + i); bus.ll_wdata = 32'hA0 + i;
      tick();
    end
    checks++;
    if ({bus.ll_ready, bus.ll_pend} !== {1'b0, 32'h0000_3C00}) begin
      $display("FAIL starve_full got ready=%b pend=%h exp ready=0 pend=00003c00", bus.ll_ready, bus.ll_pend);
      failures++;
    end
    bus.ll_waddr = 5'd14; bus.ll_wdata = 32'hA4;
    repeat (5) tick();
    checks++;
    if (bus.stall_req !== 1'b0) begin
      $display("FAIL starve_early got stall=%b exp=0", bus.stall_req);
      failures++;
    end
    tick();
    checks++;
    if ({bus.stall_req, bus.ll_ready, bus.we1, bus.waddr1, bus.we2, bus.waddr2} !== {1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2}) begin
      $display("FAIL starve_stall got stall=%b ready=%b p1=%b/%0d p2=%b/%0d exp stall=1 ready=0 p1=1/1 p2=1/2",
               bus.stall_req, bus.ll_ready, bus.we1, bus.waddr1, bus.we2, bus.waddr2);
      failures++;
    end
    bus.s1_we = 1'b0; bus.s2_we = 1'b0;
    tick();
    checks++;
    if ({bus.we1, bus.waddr1, bus.wdata1, bus.we2, bus.stall_req, bus.ll_ready} !== {1'b1, 5'd10, 32'hA0, 1'b0, 1'b0, 1'b1}) begin
      $display("FAIL starve_first_drain got p1=%b/%0d/%h we2=%b stall=%b ready=%b exp p1=1/10/a0 we2=0 stall=0 ready=1",
               bus.we1, bus.waddr1, bus.wdata1, bus.we2, bus.stall_req, bus.ll_ready);
      failures++;
    end
    for (int j = 1; j <= 4; j++) begin
      tick();
      if (j == 1) bus.ll_valid = 1'b0;
      checks++;
      if ({bus.we1, bus.waddr1, bus.wdata1} !== {1'b1, 5'(10 + j), 32'hA0 + j}) begin
        $display("FAIL starve_drain_%0d got=%b/%0d/%h exp=1/%0d/%h", j, bus.we1, bus.waddr1, bus.wdata1, 10 + j, 32'hA0 + j);
        failures++;
      end
    end
    checks++;
    if ({bus.ll_pend, bus.stall_req, bus.ll_ready} !== {32'h0, 1'b0, 1'b1}) begin
      $display("FAIL starve_done got pend=%h stall=%b ready=%b exp pend=0 stall=0 ready=1", bus.ll_pend, bus.stall_req, bus.ll_ready);
      failures++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid;
    int waited;
    bus.s1_we = 1'b1; bus.s1_waddr = 5'd1; bus.s1_wdata = 32'h5;
    bus.s2_we = 1'b1; bus.s2_waddr = 5'd2; bus.s2_wdata = 32'h6;
    for (int i = 0; i < 3; i++) begin
      bus.ll_valid = 1'b1; bus.ll_waddr = 5'(20 + i); bus.ll_wdata = 32'hC0 + i;
      tick();
    end
    bus.ll_valid = 1'b0;
    waited = 0;
    while (bus.stall_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (bus.stall_req !== 1'b1) begin
      $display("FAIL rstmid_stall_timeout got stall=%b exp=1", bus.stall_req);
      failures++;
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.we1, bus.waddr1, bus.wdata1, bus.we2, bus.waddr2, bus.wdata2} !== 76'd0) begin
      $display("FAIL rstmid_ports got=%0h exp=0", {bus.we1, bus.waddr1, bus.wdata1, bus.we2, bus.waddr2, bus.wdata2});
      failures++;
    end
    checks++;
    if ({bus.stall_req, bus.ll_ready, bus.ll_pend} !== {1'b0, 1'b1, 32'h0}) begin
      $display("FAIL rstmid_status got stall=%b ready=%b pend=%h exp stall=0 ready=1 pend=0", bus.stall_req, bus.ll_ready, bus.ll_pend);
      failures++;
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({bus.we1, bus.we2, bus.ll_pend, bus.ll_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
      $display("FAIL rstmid_quiet got we1=%b we2=%b pend=%h ready=%b exp 0 0 0 1", bus.we1, bus.we2, bus.ll_pend, bus.ll_ready);
      failures++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_slots();
    test_zero_addr();
    test_drain_port2();
    test_supersede();
    test_starvation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
